// File: rtl/mux_scan_sequencer_if.sv
// Handshake and mux-side signals of the scan sequencer.
// master: sequencer side, slave: controller/mux side.
interface mux_scan_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             START;
  logic             CONT;
  logic             ABORT;
  logic             Z;
  logic             S0;
  logic             S1;
  logic             BUSY;
  logic             VALID;
  logic [3:0]       FRAME;
  logic [CNT_W-1:0] FRAME_CNT;

  modport master (
    input  START,
    input  CONT,
    input  ABORT,
    input  Z,
    output S0,
    output S1,
    output BUSY,
    output VALID,
    output FRAME,
    output FRAME_CNT
  );

  modport slave (
    output START,
    output CONT,
    output ABORT,
    output Z,
    input  S0,
    input  S1,
    input  BUSY,
    input  VALID,
    input  FRAME,
    input  FRAME_CNT
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux through A-D, settles, samples Z,
// and returns the four samples as one frame.
module mux_scan_sequencer #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  mux_scan_sequencer_if.master bus
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_e           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       smp_q, smp_d;
  logic             valid_q, valid_d;
  logic [3:0]       frame_q, frame_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      smp_q   <= '0;
      valid_q <= 1'b0;
      frame_q <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    smp_d   = smp_q;
    valid_d = 1'b0;
    frame_d = frame_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        // ABORT blocks a same-cycle START
        if (bus.START && !bus.ABORT) begin
          state_d = SCAN;
          ch_d    = '0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (bus.ABORT) begin
          state_d = IDLE;
          ch_d    = '0;
          cnt_d   = '0;
          smp_d   = '0;
        end else if (cnt_q != SETTLE_C) begin
          cnt_d = cnt_q + 4'd1;
        end else if (ch_q != 2'd3) begin
          for (int i = 0; i < 3; i++) begin
            if (ch_q == 2'(i)) smp_d[i] = bus.Z;
          end
          ch_d  = ch_q + 2'd1;
          cnt_d = '0;
        end else begin
          frame_d = {bus.Z, smp_q};
          valid_d = 1'b1;
          fcnt_d  = fcnt_q + 1'b1;
          ch_d    = '0;
          cnt_d   = '0;
          if (!bus.CONT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.S0        = ch_q[1];
  assign bus.S1        = ch_q[0];
  assign bus.BUSY      = (state_q == SCAN);
  assign bus.VALID     = valid_q;
  assign bus.FRAME     = frame_q;
  assign bus.FRAME_CNT = fcnt_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: SETTLE=2 instance with a mux model,
// SETTLE=0 instance for continuous mode and counter wrap.
module tb_mux_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] din_a;
  logic [3:0] din_b;
  int         checks;
  int         errors;

  mux_scan_sequencer_if #(.CNT_W(8)) ifa ();
  mux_scan_sequencer_if #(.CNT_W(8)) ifb ();

  assign ifa.Z = din_a[{ifa.S0, ifa.S1}];
  assign ifb.Z = din_b[{ifb.S0, ifb.S1}];

  mux_scan_sequencer #(
    .SETTLE(2),
    .CNT_W (8)
  ) dut_a (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (ifa)
  );

  mux_scan_sequencer #(
    .SETTLE(0),
    .CNT_W (8)
  ) dut_b (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n     = 1'b0;
    ifa.START = 1'b1;
    ifb.START = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ifa.S0, ifa.S1, ifa.BUSY, ifa.VALID} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 0000",
               {ifa.S0, ifa.S1, ifa.BUSY, ifa.VALID});
    end
    checks++;
    if (ifa.FRAME !== 4'b0000 || ifa.FRAME_CNT !== 8'd0) begin
      errors++;
      $display("FAIL reset_frame: got %b/%0d want 0000/0",
               ifa.FRAME, ifa.FRAME_CNT);
    end
    checks++;
    if ({ifb.BUSY, ifb.VALID, ifb.FRAME_CNT} !== 10'd0) begin
      errors++;
      $display("FAIL reset_b: got %b want 0",
               {ifb.BUSY, ifb.VALID, ifb.FRAME_CNT});
    end
    rst_n     = 1'b1;
    ifa.START = 1'b0;
    ifb.START = 1'b0;
    @(negedge clk);
    checks++;
    if (ifa.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_nostart: got %b want 0", ifa.BUSY);
    end
  endtask

  // Starts a scan on instance A and checks the full timeline.
  task automatic scan_a(input logic [3:0] d,
                        input logic [3:0] exp_frame,
                        input int exp_cnt,
                        input int start_at,
                        input string nm);
    int bad;
    bad       = 0;
    din_a     = d;
    ifa.START = 1'b1;
    @(negedge clk);
    ifa.START = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if ({ifa.S0, ifa.S1} !== 2'(i / 3) ||
          ifa.BUSY !== 1'b1 || ifa.VALID !== 1'b0)
        bad++;
      ifa.START = (i == start_at);
    end
    ifa.START = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_seq: got %0d bad cycles want 0", nm, bad);
    end
    @(negedge clk);
    checks++;
    if ({ifa.VALID, ifa.BUSY, ifa.S0, ifa.S1} !== 4'b1000) begin
      errors++;
      $display("FAIL %s_end: got %b want 1000", nm,
               {ifa.VALID, ifa.BUSY, ifa.S0, ifa.S1});
    end
    checks++;
    if (ifa.FRAME !== exp_frame) begin
      errors++;
      $display("FAIL %s_frame: got %b want %b", nm,
               ifa.FRAME, exp_frame);
    end
    checks++;
    if (ifa.FRAME_CNT !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL %s_cnt: got %0d want %0d", nm,
               ifa.FRAME_CNT, exp_cnt);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ifa.VALID !== 1'b0 || ifa.BUSY !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_after: got %0d bad cycles want 0", nm, bad);
    end
  endtask

  task automatic test_single_frame;
    scan_a(4'b1101, 4'b1101, 1, -1, "single");
  endtask

  task automatic test_onehot;
    logic [3:0] pat [4];
    pat[0] = 4'b0001;
    pat[1] = 4'b0010;
    pat[2] = 4'b0100;
    pat[3] = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      scan_a(pat[k], pat[k], 2 + k, -1, $sformatf("onehot%0d", k));
    end
  endtask

  task automatic test_start_ignored_abort;
    int bad;
    scan_a(4'b0110, 4'b0110, 6, 4, "startin");
    din_a     = 4'b1001;
    ifa.START = 1'b1;
    @(negedge clk);
    ifa.START = 1'b0;
    for (int i = 1; i <= 6; i++) @(negedge clk);
    ifa.ABORT = 1'b1;
    @(negedge clk);
    ifa.ABORT = 1'b0;
    checks++;
    if ({ifa.BUSY, ifa.S0, ifa.S1, ifa.VALID} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_ctl: got %b want 0000",
               {ifa.BUSY, ifa.S0, ifa.S1, ifa.VALID});
    end
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (ifa.VALID !== 1'b0 || ifa.BUSY !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (ifa.FRAME !== 4'b0110 || ifa.FRAME_CNT !== 8'd6) begin
      errors++;
      $display("FAIL abort_keep: got %b/%0d want 0110/6",
               ifa.FRAME, ifa.FRAME_CNT);
    end
  endtask

  task automatic test_cont_wrap;
    int bad;
    int cnt_at_1016;
    int cnt_at_1020;
    int cnt_at_1024;
    bad       = 0;
    din_b     = 4'b1010;
    ifb.CONT  = 1'b1;
    ifb.START = 1'b1;
    @(negedge clk);
    ifb.START = 1'b0;
    cnt_at_1016 = -1;
    cnt_at_1020 = -1;
    cnt_at_1024 = -1;
    for (int j = 1; j <= 1028; j++) begin
      @(negedge clk);
      if (ifb.BUSY !== (j < 1028)) bad++;
      if (ifb.VALID !== (j % 4 == 0)) bad++;
      if (j == 1016) cnt_at_1016 = int'(ifb.FRAME_CNT);
      if (j == 1020) cnt_at_1020 = int'(ifb.FRAME_CNT);
      if (j == 1024) cnt_at_1024 = int'(ifb.FRAME_CNT);
      if (j == 1025) ifb.CONT = 1'b0;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL cont_timing: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (cnt_at_1016 != 254) begin
      errors++;
      $display("FAIL cont_254: got %0d want 254", cnt_at_1016);
    end
    checks++;
    if (cnt_at_1020 != 255) begin
      errors++;
      $display("FAIL cont_255: got %0d want 255", cnt_at_1020);
    end
    checks++;
    if (cnt_at_1024 != 0) begin
      errors++;
      $display("FAIL cont_wrap: got %0d want 0", cnt_at_1024);
    end
    checks++;
    if (ifb.FRAME !== 4'b1010 || ifb.FRAME_CNT !== 8'd1) begin
      errors++;
      $display("FAIL cont_stop: got %b/%0d want 1010/1",
               ifb.FRAME, ifb.FRAME_CNT);
    end
  endtask

  task automatic test_reset_midframe;
    int bad;
    din_a     = 4'b0101;
    ifa.START = 1'b1;
    @(negedge clk);
    ifa.START = 1'b0;
    for (int i = 1; i <= 7; i++) @(negedge clk);
    checks++;
    if ({ifa.S0, ifa.S1} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_ch: got %b want 10", {ifa.S0, ifa.S1});
    end
    rst_n     = 1'b0;
    ifa.ABORT = 1'b1;
    ifa.START = 1'b1;
    @(negedge clk);
    rst_n     = 1'b1;
    ifa.ABORT = 1'b0;
    ifa.START = 1'b0;
    checks++;
    if ({ifa.S0, ifa.S1, ifa.BUSY, ifa.VALID,
         ifa.FRAME, ifa.FRAME_CNT} !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_zero: got %b want 0",
               {ifa.S0, ifa.S1, ifa.BUSY, ifa.VALID,
                ifa.FRAME, ifa.FRAME_CNT});
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifa.VALID !== 1'b0 || ifa.BUSY !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: got %0d bad cycles want 0", bad);
    end
    scan_a(4'b0101, 4'b0101, 1, -1, "rstmid_clean");
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    din_a     = 4'b0000;
    din_b     = 4'b0000;
    ifa.START = 1'b0;
    ifa.CONT  = 1'b0;
    ifa.ABORT = 1'b0;
    ifb.START = 1'b0;
    ifb.CONT  = 1'b0;
    ifb.ABORT = 1'b0;
    test_reset();
    test_single_frame();
    test_onehot();
    test_start_ignored_abort();
    test_cont_wrap();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
